corefifo_wr_ptr_gen: RTL and testbench

Write-side pointer and flag generator for the dual-clock FIFO, running entirely in the write clock domain. It holds the binary write pointer and drives the RAM write address and enable. It registers the Gray-coded write pointer that the read domain synchronizes. It also decodes the already-synchronized Gray read pointer back to binary to produce a registered word count, `full`, `afull` and an overflow strobe.

---
 rtl/corefifo_pkg.sv | 25 ++
 rtl/corefifo_gray2bin.sv | 22 ++
 rtl/corefifo_wr_ptr_gen.sv | 67 ++++++
 tb/tb_corefifo_wr_ptr_gen.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/corefifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer generators.
// Latency: pure functions and constants, no state.
// Backpressure: not applicable.
package corefifo_pkg;

    localparam int ADDRWIDTH_DEF = 3;
    localparam int PTRW          = ADDRWIDTH_DEF + 1;
    localparam int DEPTH         = 2 ** ADDRWIDTH_DEF;

    // Width-agnostic: callers zero-extend to 32 bits and truncate the result.
    function automatic logic [31:0] bin2gray(input logic [31:0] v);
        return v ^ (v >> 1);
    endfunction

    // MSB-first prefix XOR; leading zeros from extension do not disturb the result.
    function automatic logic [31:0] gray2bin(input logic [31:0] v);
        logic [31:0] b;
        b[31] = v[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i + 1] ^ v[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/corefifo_gray2bin.sv
// Combinational Gray-to-binary decode of an ADDRWIDTH+1 bit FIFO pointer.
// Latency: zero cycles, pure combinational.
// Backpressure: none; output follows input.
module corefifo_gray2bin #(
    parameter int ADDRWIDTH = 3
) (
    input  logic [ADDRWIDTH:0] gray,
    output logic [ADDRWIDTH:0] bin
);

    // Decode from the MSB down; a local variable keeps the ripple out of the port net.
    always_comb begin
        logic [ADDRWIDTH:0] b;
        b            = '0;
        b[ADDRWIDTH] = gray[ADDRWIDTH];
        for (int i = ADDRWIDTH - 1; i >= 0; i--) begin
            b[i] = b[i + 1] ^ gray[i];
        end
        bin = b;
    end

endmodule

// File: rtl/corefifo_wr_ptr_gen.sv
// Write-side pointer, Gray pointer and occupancy/flag generator (write clock domain).
// Latency: waddr/wen_mem same cycle as we; wptr_gray/wcount/full/afull one edge later.
// Backpressure: writes are refused while full (pessimistic); a refused write pulses overflow.
module corefifo_wr_ptr_gen
    import corefifo_pkg::*;
#(
    parameter int ADDRWIDTH = 3,
    parameter int AFULL_VAL = 6
) (
    input  logic                 wclock,
    input  logic                 wreset,
    input  logic                 we,
    input  logic [ADDRWIDTH:0]   rptr_gray_sync,
    output logic [ADDRWIDTH-1:0] waddr,
    output logic                 wen_mem,
    output logic [ADDRWIDTH:0]   wptr_gray,
    output logic [ADDRWIDTH:0]   wcount,
    output logic                 full,
    output logic                 afull,
    output logic                 overflow
);

    localparam int             PW        = ADDRWIDTH + 1;
    localparam logic [PW-1:0]  FULL_CNT  = PW'(1) << ADDRWIDTH;
    localparam logic [PW-1:0]  AFULL_LVL = PW'(AFULL_VAL);

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_nxt;
    logic [PW-1:0] rbin;
    logic [PW-1:0] cnt_nxt;
    logic          acc;

    // Read pointer arrives already synchronized; only the decode happens here.
    corefifo_gray2bin #(
        .ADDRWIDTH (ADDRWIDTH)
    ) u_rptr_dec (
        .gray (rptr_gray_sync),
        .bin  (rbin)
    );

    assign acc      = we & ~full;
    assign wen_mem  = acc;
    assign waddr    = wbin[ADDRWIDTH-1:0];
    assign wbin_nxt = wbin + {{(PW-1){1'b0}}, acc};
    // Using the next write pointer means an accept and a read advance in the same cycle cancel.
    assign cnt_nxt  = wbin_nxt - rbin;

    // Pointer, Gray copy and flags all move together on the write clock.
    always_ff @(posedge wclock) begin
        if (wreset) begin
            wbin      <= '0;
            wptr_gray <= '0;
            wcount    <= '0;
            full      <= 1'b0;
            afull     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            wbin      <= wbin_nxt;
            wptr_gray <= wbin_nxt ^ (wbin_nxt >> 1);
            wcount    <= cnt_nxt;
            full      <= (cnt_nxt == FULL_CNT);
            afull     <= (cnt_nxt >= AFULL_LVL);
            overflow  <= we & full;
        end
    end

endmodule

// File: tb/tb_corefifo_wr_ptr_gen.sv
// Bench for corefifo_wr_ptr_gen: directed vectors feed an expectation queue,
// a negedge monitor pops one entry per cycle and compares every output.
// Last phase uses a small occupancy model with the read pointer lagging two cycles.
module tb_corefifo_wr_ptr_gen;
    import corefifo_pkg::*;

    logic       clk;
    logic       wreset;
    logic       we;
    logic [3:0] rp;
    logic [2:0] waddr;
    logic       wen_mem;
    logic [3:0] wptr_gray;
    logic [3:0] wcount;
    logic       full;
    logic       afull;
    logic       overflow;

    corefifo_wr_ptr_gen #(
        .ADDRWIDTH (3),
        .AFULL_VAL (6)
    ) dut (
        .wclock         (clk),
        .wreset         (wreset),
        .we             (we),
        .rptr_gray_sync (rp),
        .waddr          (waddr),
        .wen_mem        (wen_mem),
        .wptr_gray      (wptr_gray),
        .wcount         (wcount),
        .full           (full),
        .afull          (afull),
        .overflow       (overflow)
    );

    typedef struct {
        logic [2:0] waddr;
        logic       wen;
        logic [3:0] gray;
        logic [3:0] cnt;
        logic       full;
        logic       afull;
        logic       ovf;
        bit         mdl;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   wrap_seen = 0;
    logic [3:0] prev_gray = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", name, act, req);
        end
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle away from the edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("waddr",    int'(waddr),     int'(e.waddr));
            chk("wen_mem",  int'(wen_mem),   int'(e.wen));
            chk("wptr_gray",int'(wptr_gray), int'(e.gray));
            chk("wcount",   int'(wcount),    int'(e.cnt));
            chk("full",     int'(full),      int'(e.full));
            chk("afull",    int'(afull),     int'(e.afull));
            chk("overflow", int'(overflow),  int'(e.ovf));
            if (e.mdl) begin
                chk("gray_1bit", int'($countones(prev_gray ^ wptr_gray) <= 1), 1);
                chk("wcount_le8", int'(wcount <= 4'd8), 1);
                if (prev_gray == 4'd8 && wptr_gray == 4'd0) wrap_seen++;
            end
            prev_gray = wptr_gray;
        end
    end

    task automatic go(input logic r, input logic w, input logic [3:0] p,
                      input logic [2:0] a, input logic en, input logic [3:0] g,
                      input logic [3:0] c, input logic f, input logic af, input logic o,
                      input bit mdl);
        exp_t e;
        @(posedge clk);
        #1;
        wreset = r;
        we     = w;
        rp     = p;
        e.waddr = a; e.wen = en; e.gray = g; e.cnt = c;
        e.full = f; e.afull = af; e.ovf = o; e.mdl = mdl;
        exp_q.push_back(e);
    endtask

    function automatic logic [3:0] g4(input int v);
        logic [31:0] t;
        t = bin2gray(32'(v));
        return t[3:0];
    endfunction

    initial begin
        int   mw, mc, rb;
        bit   mf, ma, mo, acc;
        int   hist[$];

        wreset = 1'b1;
        we     = 1'b0;
        rp     = 4'd0;
        repeat (2) @(posedge clk);

        //  rst we rp   waddr wen gray cnt full afull ovf
        go(1, 1, 0,     0, 1,  0, 0, 0, 0, 0, 0);   // in reset, write discarded
        go(0, 1, 0,     0, 1,  0, 0, 0, 0, 0, 0);
        go(0, 1, 0,     1, 1,  1, 1, 0, 0, 0, 0);
        go(0, 1, 0,     2, 1,  3, 2, 0, 0, 0, 0);
        go(0, 1, 0,     3, 1,  2, 3, 0, 0, 0, 0);
        go(0, 1, 0,     4, 1,  6, 4, 0, 0, 0, 0);
        go(0, 1, 0,     5, 1,  7, 5, 0, 0, 0, 0);
        go(0, 1, 0,     6, 1,  5, 6, 0, 1, 0, 0);   // afull after 6th write
        go(0, 1, 0,     7, 1,  4, 7, 0, 1, 0, 0);
        go(0, 1, 0,     0, 0, 12, 8, 1, 1, 0, 0);   // full, write refused
        go(0, 1, 0,     0, 0, 12, 8, 1, 1, 1, 0);
        go(0, 1, 0,     0, 0, 12, 8, 1, 1, 1, 0);
        go(0, 0, 0,     0, 0, 12, 8, 1, 1, 1, 0);   // third overflow pulse
        go(0, 0, 1,     0, 0, 12, 8, 1, 1, 0, 0);   // read ptr steps to 1
        go(0, 1, 1,     0, 1, 12, 7, 0, 1, 0, 0);   // space freed, write accepted
        go(0, 0, 1,     1, 0, 13, 8, 1, 1, 0, 0);   // full again
        go(0, 0, 6,     1, 0, 13, 8, 1, 1, 0, 0);   // read ptr jumps to 4
        go(0, 1, 7,     1, 1, 13, 5, 0, 0, 0, 0);   // write + read advance together
        go(0, 0, 7,     2, 0, 15, 5, 0, 0, 0, 0);   // count held at 5
        go(0, 0, 5,     2, 0, 15, 5, 0, 0, 0, 0);   // read ptr to 6
        go(1, 1, 5,     2, 1, 15, 4, 0, 0, 0, 0);   // reset at count 4 with we
        go(0, 0, 0,     0, 0,  0, 0, 0, 0, 0, 0);   // everything cleared
        go(0, 1, 0,     0, 1,  0, 0, 0, 0, 0, 0);   // pointer still 0: write was dropped
        go(0, 0, 0,     1, 0,  1, 1, 0, 0, 0, 0);

        // 40 writes, read pointer following the write pointer two cycles late.
        mw = 1; mc = 1; mf = 0; ma = 0; mo = 0;
        hist.push_back(0);
        hist.push_back(1);
        for (int i = 0; i < 40; i++) begin
            rb = hist.pop_front();
            go(0, 1, g4(rb), 3'(mw % 8), !mf, g4(mw), 4'(mc), mf, ma, mo, 1);
            acc = !mf;
            mo  = mf;
            mw  = (mw + int'(acc)) % 16;
            mc  = (mw - rb + 16) % 16;
            mf  = (mc == 8);
            ma  = (mc >= 6);
            hist.push_back(mw);
        end

        @(posedge clk);
        #1;
        we = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        chk("gray_wrap_8_to_0", int'(wrap_seen > 0), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
